// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I sequencer and its ALU decoder.
package riscv_ctrl_pkg;

  localparam int unsigned OPCODE_W     = 7;
  localparam int unsigned FUNCT3_W     = 3;
  localparam int unsigned FUNCT7_W     = 7;
  localparam int unsigned ALU_CC_WIDTH = 4;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Supported major opcodes
  localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;

  // funct3 selectors for the integer ALU group
  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;

  // ALU control codes
  localparam logic [ALU_CC_WIDTH-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_SRL = 4'b1001;
  localparam logic [ALU_CC_WIDTH-1:0] ALU_SRA = 4'b1010;

  // Instruction fields captured in DECODE
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
  } inst_fields_t;

  // Opcodes the sequencer knows how to execute
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Opcodes that need a data-memory access
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct -> ALU control code mapping.
// Loads and stores always add (address generation); R and I-ALU use funct3,
// with funct7[5] selecting SUB (R only) and SRA (R and I shifts).
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0]     opcode_i,
  input  logic [FUNCT3_W-1:0]     funct3_i,
  input  logic [FUNCT7_W-1:0]     funct7_i,
  output logic [ALU_CC_WIDTH-1:0] alu_cc_c_o
);

  logic is_r_c;
  logic is_alu_c;
  logic alt_c;
  logic unused_funct7_c;

  assign is_r_c   = (opcode_i == OP_R);
  assign is_alu_c = is_r_c || (opcode_i == OP_I);
  assign alt_c    = funct7_i[5];

  // Only funct7[5] carries meaning for the supported instructions
  assign unused_funct7_c = ^{funct7_i[6], funct7_i[4:0]};

  // Select the ALU operation; anything unlisted falls back to ADD
  always_comb begin
    alu_cc_c_o = ALU_ADD;
    if (is_alu_c) begin
      case (funct3_i)
        F3_ADD_SUB: alu_cc_c_o = (is_r_c && alt_c) ? ALU_SUB : ALU_ADD;
        F3_SLL:     alu_cc_c_o = ALU_SLL;
        F3_SLT:     alu_cc_c_o = ALU_SLT;
        F3_XOR:     alu_cc_c_o = ALU_XOR;
        F3_SRL_SRA: alu_cc_c_o = alt_c ? ALU_SRA : ALU_SRL;
        F3_OR:      alu_cc_c_o = ALU_OR;
        F3_AND:     alu_cc_c_o = ALU_AND;
        default:    alu_cc_c_o = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Control outputs are flops loaded from the next-state decode, so they carry
// no input-to-output path; only pc_write/ir_write follow inst_valid in FETCH.
module mc_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CC_W = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                inst_valid,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_t       state_q, state_d;
  inst_fields_t fields_q, fields_d;

  logic                    reg_write_q, reg_write_d;
  logic                    mem2reg_q, mem2reg_d;
  logic                    alu_src_q, alu_src_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ALU_CC_W-1:0]     alu_cc_q, alu_cc_d;
  logic                    illegal_q, illegal_d;
  logic [CNT_W-1:0]        retired_q;
  logic                    retire_c;
  logic [ALU_CC_WIDTH-1:0] dec_cc_c;
  logic                    ld_d, st_d;

  // ALU code for the fields that will be held next cycle
  alu_decoder u_alu_decoder (
    .opcode_i   (fields_d.opcode),
    .funct3_i   (fields_d.funct3),
    .funct7_i   (fields_d.funct7),
    .alu_cc_c_o (dec_cc_c)
  );

  // Next state and field capture
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    case (state_q)
      ST_FETCH: begin
        if (inst_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        fields_d = '{opcode: opcode, funct3: funct3, funct7: funct7};
        state_d  = is_legal_op(opcode) ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        state_d = is_mem_op(fields_q.opcode) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) state_d = (fields_q.opcode == OP_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // An instruction completes when WB ends or a store's memory access finishes
  assign retire_c = (state_q == ST_WB) ||
                    ((state_q == ST_MEM) && mem_ready && (fields_q.opcode == OP_STORE));

  assign ld_d = (fields_d.opcode == OP_LOAD);
  assign st_d = (fields_d.opcode == OP_STORE);

  // Control values for the state being entered
  always_comb begin
    reg_write_d = 1'b0;
    mem2reg_d   = 1'b0;
    alu_src_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_cc_d    = ALU_CC_W'(ALU_ADD);
    illegal_d   = 1'b0;
    case (state_d)
      ST_EXEC: begin
        alu_cc_d  = ALU_CC_W'(dec_cc_c);
        alu_src_d = (fields_d.opcode != OP_R);
      end
      ST_MEM: begin
        alu_src_d   = 1'b1;
        mem_read_d  = ld_d;
        mem_write_d = st_d;
      end
      ST_WB: begin
        reg_write_d = 1'b1;
        mem2reg_d   = ld_d;
        alu_cc_d    = ALU_CC_W'(dec_cc_c);
        alu_src_d   = (fields_d.opcode != OP_R);
      end
      ST_TRAP: illegal_d = 1'b1;
      default: ;
    endcase
  end

  // State, latched fields, control flops and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      fields_q    <= '0;
      reg_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_cc_q    <= ALU_CC_W'(ALU_ADD);
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      fields_q    <= fields_d;
      reg_write_q <= reg_write_d;
      mem2reg_q   <= mem2reg_d;
      alu_src_q   <= alu_src_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_cc_q    <= alu_cc_d;
      illegal_q   <= illegal_d;
      if (retire_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign pc_write  = (state_q == ST_FETCH) && inst_valid;
  assign ir_write  = (state_q == ST_FETCH) && inst_valid;
  assign reg_write = reg_write_q;
  assign mem2reg   = mem2reg_q;
  assign alu_src   = alu_src_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign alu_cc    = alu_cc_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the stimulus side expands each
// instruction into its expected per-cycle control pattern and queues it;
// a monitor compares every cycle at the falling edge.
module tb_mc_control_fsm;

  typedef struct packed {
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem2reg;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_cc;
    logic        illegal;
    logic [31:0] retired;
  } obs_t;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        inst_valid;
  logic        mem_ready;
  logic        pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write;
  logic [3:0]  alu_cc;
  logic        illegal;
  logic [31:0] retired;

  obs_t        exp_q[$];
  logic [31:0] retired_m;
  int          n_vec;
  int          n_err;

  mc_control_fsm #(.ALU_CC_W(4), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .inst_valid (inst_valid),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem2reg    (mem2reg),
    .alu_src    (alu_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_cc     (alu_cc),
    .illegal    (illegal),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU code, straight from the instruction-set rules
  function automatic logic [3:0] ref_cc(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    if (op != 7'b0110011 && op != 7'b0010011) return 4'b0010;  // address add
    case (f3)
      3'd0:    return (op == 7'b0110011 && f7[5]) ? 4'b0110 : 4'b0010;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0111;
      3'd4:    return 4'b0011;
      3'd5:    return f7[5] ? 4'b1010 : 4'b1001;
      3'd6:    return 4'b0001;
      3'd7:    return 4'b0000;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o         = '0;
    o.alu_cc  = 4'b0010;
    o.retired = retired_m;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.pc_write  = pc_write;
    o.ir_write  = ir_write;
    o.reg_write = reg_write;
    o.mem2reg   = mem2reg;
    o.alu_src   = alu_src;
    o.mem_read  = mem_read;
    o.mem_write = mem_write;
    o.alu_cc    = alu_cc;
    o.illegal   = illegal;
    o.retired   = retired;
    return o;
  endfunction

  // One clock of stimulus plus the control pattern expected during it
  task automatic step(input logic rst, input logic iv, input logic mr,
                      input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input obs_t e);
    reset      = rst;
    inst_valid = iv;
    mem_ready  = mr;
    opcode     = op;
    funct3     = f3;
    funct7     = f7;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Same, with garbage on the instruction fields
  task automatic jstep(input logic rst, input logic iv, input logic mr, input obs_t e);
    step(rst, iv, mr, 7'($urandom), 3'($urandom), 7'($urandom), e);
  endtask

  // Expand one instruction into cycles. fst/mst are FETCH/MEM stall counts;
  // rst_at >= 0 asserts reset in that MEM cycle instead of finishing.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fst, input int mst, input int rst_at);
    obs_t       e;
    logic [3:0] cc;
    logic       is_r, is_ld, is_st, legal;
    is_r  = (op == 7'b0110011);
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    legal = is_r || is_ld || is_st || (op == 7'b0010011);
    cc    = ref_cc(op, f3, f7);

    for (int k = 0; k < fst; k++) jstep(1'b0, 1'b0, 1'($urandom), idle_obs());
    e = idle_obs(); e.pc_write = 1'b1; e.ir_write = 1'b1;
    jstep(1'b0, 1'b1, 1'($urandom), e);
    step(1'b0, 1'($urandom), 1'($urandom), op, f3, f7, idle_obs());

    if (!legal) begin
      for (int k = 0; k < 12; k++) begin
        e = idle_obs(); e.illegal = 1'b1;
        jstep(1'b0, 1'($urandom), 1'($urandom), e);
      end
      e = idle_obs(); e.illegal = 1'b1;
      jstep(1'b1, 1'b0, 1'($urandom), e);
      retired_m = '0;
      return;
    end

    e = idle_obs(); e.alu_cc = cc; e.alu_src = !is_r;
    jstep(1'b0, 1'($urandom), 1'($urandom), e);

    if (is_ld || is_st) begin
      for (int k = 0; k <= mst; k++) begin
        e = idle_obs(); e.alu_src = 1'b1; e.mem_read = is_ld; e.mem_write = is_st;
        if (k == rst_at) begin
          jstep(1'b1, 1'b0, 1'b0, e);
          retired_m = '0;
          return;
        end
        jstep(1'b0, 1'($urandom), (k == mst), e);
      end
      if (is_st) begin
        retired_m = retired_m + 32'd1;
        return;
      end
    end

    e = idle_obs(); e.reg_write = 1'b1; e.mem2reg = is_ld; e.alu_cc = cc; e.alu_src = !is_r;
    jstep(1'b0, 1'($urandom), 1'($urandom), e);
    retired_m = retired_m + 32'd1;
  endtask

  // Monitor: compare each presented cycle against the queued expectation
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample_dut();
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL ctrl vec %0d t=%0t: got pcw=%b irw=%b rw=%b m2r=%b src=%b rd=%b wr=%b cc=%b ill=%b ret=%0d; want pcw=%b irw=%b rw=%b m2r=%b src=%b rd=%b wr=%b cc=%b ill=%b ret=%0d",
                   n_vec, $time, a.pc_write, a.ir_write, a.reg_write, a.mem2reg, a.alu_src,
                   a.mem_read, a.mem_write, a.alu_cc, a.illegal, a.retired,
                   e.pc_write, e.ir_write, e.reg_write, e.mem2reg, e.alu_src,
                   e.mem_read, e.mem_write, e.alu_cc, e.illegal, e.retired);
        end
        n_vec++;
        if ((32'(a.reg_write) + 32'(a.mem_read) + 32'(a.mem_write)) > 32'd1) begin
          n_err++;
          $display("FAIL onehot t=%0t: rw=%b rd=%b wr=%b, want at most one high",
                   $time, a.reg_write, a.mem_read, a.mem_write);
        end
      end
    end
  end

  // Hard time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         sel, mst, rst_at;
    n_vec      = 0;
    n_err      = 0;
    retired_m  = '0;
    reset      = 1'b1;
    inst_valid = 1'b0;
    mem_ready  = 1'b0;
    opcode     = '0;
    funct3     = '0;
    funct7     = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 7'd0, idle_obs());

    // Directed cases
    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, -1);  // ADD
    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, -1);  // SUB
    run_instr(7'b0110011, 3'b101, 7'b0100000, 0, 0, -1);  // SRA
    run_instr(7'b0110011, 3'b101, 7'b0000000, 0, 0, -1);  // SRL
    run_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0, -1);  // SRAI
    run_instr(7'b0010011, 3'b000, 7'b0100000, 0, 0, -1);  // ADDI, funct7[5] ignored
    run_instr(7'b0110011, 3'b011, 7'b0000000, 0, 0, -1);  // unused funct3 -> ADD
    run_instr(7'b0000011, 3'b010, 7'b0000000, 0, 3, -1);  // LOAD, 3 stalls
    run_instr(7'b0100011, 3'b010, 7'b0000000, 2, 1, -1);  // STORE, fetch stalls
    run_instr(7'b1110011, 3'b000, 7'b0000000, 0, 0, -1);  // illegal -> TRAP, reset
    run_instr(7'b0100011, 3'b010, 7'b0000000, 0, 5, 2);   // STORE aborted by reset
    run_instr(7'b0110011, 3'b111, 7'b0000000, 0, 0, -1);  // AND after abort

    // Random instruction stream
    for (int n = 0; n < 180; n++) begin
      sel    = int'($urandom_range(0, 19));
      f3     = 3'($urandom);
      f7     = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'($urandom);
      mst    = int'($urandom_range(0, 3));
      rst_at = -1;
      if (sel < 5)       op = 7'b0110011;
      else if (sel < 10) op = 7'b0010011;
      else if (sel < 14) op = 7'b0000011;
      else if (sel < 18) op = 7'b0100011;
      else if (sel == 18) begin
        op = 7'($urandom);
        while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b0100011)
          op = 7'($urandom);
      end else begin
        op     = ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'b0100011;
        mst    = int'($urandom_range(1, 3));
        rst_at = int'($urandom_range(0, 32'(mst - 1)));
      end
      run_instr(op, f3, f7, int'($urandom_range(0, 2)), mst, rst_at);
    end
    jstep(1'b0, 1'b0, 1'($urandom), idle_obs());

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
